dac_fifo_sched: RTL and testbench

DAC_FIFO_SCHED -- requirements
Module: dac_fifo_sched

---
 rtl/adda_pkg.sv | 13 +
 rtl/dac_fifo_sched_rate_tick_gen.sv | 35 +++
 rtl/dac_fifo_sched.sv | 132 +++++++++++++
 tb/tb_dac_fifo_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adda_pkg.sv
// Shared definitions for the ADC/DAC data-path blocks: scheduler state encoding and idle DAC code.
package adda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_STREAM   = 2'd2,
    ST_UNDERRUN = 2'd3
  } sched_state_t;

  localparam logic [13:0] DAC_MIDSCALE = 14'h2000;

endpackage

// File: rtl/dac_fifo_sched_rate_tick_gen.sv
// Sample-rate divider: counts 0..RATE_DIV-1 and flags the last count as a tick.
module rate_tick_gen #(
  parameter int RATE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Held at zero while cleared, so no tick can escape outside streaming.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dac_fifo_sched.sv
// Paces FIFO reads to the DAC sample rate with prime/underrun recovery.
// Optional saturating underrun counter port enabled by DAC_SCHED_UNDERRUN_CNT_EN.
module dac_fifo_sched
  import adda_pkg::*;
#(
  parameter int FIFO_WIDTH = 14,
  parameter int FIFO_DEPTH = 64,
  parameter int RATE_DIV   = 4,
  parameter int PRIME_LVL  = 32,
  parameter logic [FIFO_WIDTH-1:0] MIDSCALE = DAC_MIDSCALE,
  localparam int CW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CW-1:0]         fifo_count,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic [FIFO_WIDTH-1:0] dac_data,
  output logic                  dac_valid,
  output logic                  underrun,
  output logic [1:0]            state
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam logic [CW-1:0] PRIME_THR = CW'(PRIME_LVL);

  sched_state_t          state_q, state_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  dac_valid_q, dac_valid_d;
  logic [FIFO_WIDTH-1:0] dac_data_q, dac_data_d;
  logic                  rate_clr;
  logic                  tick;
  logic                  rd_en;
  logic                  urun;

  assign rate_clr = (state_q != ST_STREAM);

  rate_tick_gen #(
    .RATE_DIV(RATE_DIV)
  ) u_rate_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (rate_clr),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    urun    = 1'b0;

    // A dropping enable wins over a tick: no new read, no underrun report.
    if ((state_q == ST_STREAM) && enable && tick) begin
      if (fifo_empty) begin
        urun = 1'b1;
      end else begin
        rd_en = 1'b1;
      end
    end

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_PRIME;
        ST_PRIME:    if (fifo_count >= PRIME_THR) state_d = ST_STREAM;
        ST_STREAM:   if (urun) state_d = ST_UNDERRUN;
        ST_UNDERRUN: state_d = ST_PRIME;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_pend_d   = rd_en;
    dac_valid_d = rd_pend_q;
    dac_data_d  = dac_data_q;
    // An in-flight read is always captured first; midscale follows a cycle later.
    if (rd_pend_q) begin
      dac_data_d = fifo_rd_data;
    end else if (!enable || (state_q == ST_IDLE)) begin
      dac_data_d = MIDSCALE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_pend_q   <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= MIDSCALE;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      dac_valid_q <= dac_valid_d;
      dac_data_q  <= dac_data_d;
    end
  end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q, urun_cnt_d;

  always_comb begin
    urun_cnt_d = urun_cnt_q;
    if (urun && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_d = urun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      urun_cnt_q <= '0;
    end else begin
      urun_cnt_q <= urun_cnt_d;
    end
  end

  assign underrun_cnt = urun_cnt_q;
`endif

  assign fifo_rd_en = rd_en;
  assign underrun   = urun;
  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dac_fifo_sched.sv
// Self-checking bench for dac_fifo_sched with a queue-based FIFO model and read scoreboard.
module tb_dac_fifo_sched;

  localparam int W  = 14;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_rd_data;
  logic [W-1:0]  dac_data;
  logic          dac_valid;
  logic          underrun;
  logic [1:0]    state;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  dac_fifo_sched dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .underrun    (underrun),
    .state       (state)
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  typedef struct {
    logic       en;
    int         push;
    logic [1:0] st;
    logic       rd;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc_n  = 0;
  logic [W-1:0] q[$];
  exp_t         sb[$];
  logic [W-1:0] next_word = 14'h0100;
  logic [W-1:0] last_popped = '0;
  vec_t         vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing (cycle %0d)", name, cyc_n);
  endtask

  task automatic upd_fifo();
    fifo_count = CW'(q.size());
    fifo_empty = (q.size() == 0);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(next_word);
      next_word = next_word + 14'd1;
    end
    upd_fifo();
  endtask

  // Observe one cycle at the falling edge; scoreboard the DAC capture side.
  task automatic look();
    exp_t e;
    @(negedge clk);
    if (fifo_rd_en) check("rd_not_empty", int'(fifo_empty), 0);
    while (sb.size() > 0 && sb[0].due < cyc_n) begin
      fail_now("dac_valid_missing");
      void'(sb.pop_front());
    end
    if (dac_valid) begin
      if (sb.size() == 0) begin
        fail_now("dac_valid_expected_none");
      end else begin
        e = sb.pop_front();
        check("valid_cycle", cyc_n, e.due);
        check("dac_word", int'(dac_data), int'(e.data));
        $display("cycle %0d: dac word %h", cyc_n, dac_data);
      end
    end
  endtask

  // Advance through the rising edge and let the FIFO model answer any read.
  task automatic adv();
    logic rd_s, rst_s;
    rd_s  = fifo_rd_en;
    rst_s = rst;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rd_s && q.size() > 0) begin
      last_popped  = q.pop_front();
      fifo_rd_data = last_popped;
      if (!rst_s) sb.push_back('{data: last_popped, due: cyc_n + 1});
      $display("cycle %0d: fifo read %h%s", cyc_n, last_popped, rst_s ? " (reset)" : "");
    end
    upd_fifo();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int last_rd;
    logic [W-1:0] w;

    vecs[0]  = '{1'b1, 0,  2'd0, 1'b0};
    vecs[1]  = '{1'b1, 10, 2'd1, 1'b0};
    vecs[2]  = '{1'b1, 10, 2'd1, 1'b0};
    vecs[3]  = '{1'b1, 11, 2'd1, 1'b0};
    vecs[4]  = '{1'b1, 1,  2'd1, 1'b0};
    vecs[5]  = '{1'b1, 0,  2'd2, 1'b0};
    vecs[6]  = '{1'b1, 0,  2'd2, 1'b0};
    vecs[7]  = '{1'b1, 0,  2'd2, 1'b0};
    vecs[8]  = '{1'b1, 0,  2'd2, 1'b1};
    vecs[9]  = '{1'b1, 0,  2'd2, 1'b0};
    vecs[10] = '{1'b1, 0,  2'd2, 1'b0};

    rst = 1'b1;
    enable = 1'b0;
    fifo_rd_data = '0;
    upd_fifo();
    for (int i = 0; i < 3; i++) begin
      look();
      adv();
    end
    look();
    check("rst_state", int'(state), 0);
    check("rst_dac_data", int'(dac_data), 'h2000);
    check("rst_dac_valid", int'(dac_valid), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    rst = 1'b0;
    adv();

    // Priming and first read, table driven
    last_rd = -1;
    for (int i = 0; i < 11; i++) begin
      enable = vecs[i].en;
      push(vecs[i].push);
      look();
      check($sformatf("prime_state_%0d", i), int'(state), int'(vecs[i].st));
      check($sformatf("prime_rd_%0d", i), int'(fifo_rd_en), int'(vecs[i].rd));
      if (fifo_rd_en) last_rd = cyc_n;
      adv();
    end

    // Full FIFO streaming: one read every RATE_DIV cycles
    push(32);
    check("fifo_full_count", int'(fifo_count), 63);
    for (int i = 0; i < 40; i++) begin
      look();
      if (fifo_rd_en) begin
        if (last_rd >= 0) check("rd_period", cyc_n - last_rd, 4);
        last_rd = cyc_n;
      end
      adv();
    end

    // Drain to empty: underrun, hold, re-prime
    found = 0;
    for (int i = 0; i < 400; i++) begin
      look();
      if (underrun) begin
        found = 1;
        check("urun_empty", int'(fifo_empty), 1);
        check("urun_no_rd", int'(fifo_rd_en), 0);
        check("urun_state_stream", int'(state), 2);
        check("urun_hold", int'(dac_data), int'(last_popped));
        adv();
        break;
      end
      adv();
    end
    if (!found) begin
      fail_now("underrun_timeout");
    end else begin
      look();
      check("urun_state3", int'(state), 3);
      check("urun_one_cycle", int'(underrun), 0);
      check("urun_hold2", int'(dac_data), int'(last_popped));
      adv();
      look();
      check("urun_state1", int'(state), 1);
      check("reprime_hold", int'(dac_data), int'(last_popped));
      adv();
    end
    push(32);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (fifo_rd_en) begin
        found = 1;
        adv();
        break;
      end
      adv();
    end
    if (!found) fail_now("resume_rd_timeout");
    for (int i = 0; i < 3; i++) begin
      look();
      adv();
    end

    // Enable dropped the cycle after a read
    found = 0;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      look();
      if (fifo_rd_en) begin
        found = 1;
        w = q[0];
        break;
      end
      adv();
    end
    if (!found) begin
      fail_now("drop_rd_timeout");
    end else begin
      adv();
      enable = 1'b0;
      look();
      check("drop_state_t1", int'(state), 2);
      check("drop_valid_t1", int'(dac_valid), 0);
      adv();
      look();
      check("drop_valid_t2", int'(dac_valid), 1);
      check("drop_state_t2", int'(state), 0);
      check("drop_word_t2", int'(dac_data), int'(w));
      adv();
      look();
      check("drop_midscale", int'(dac_data), 'h2000);
      check("drop_state_t3", int'(state), 0);
      check("drop_valid_t3", int'(dac_valid), 0);
      adv();
    end

    // Reset coincident with a read mid-stream
    q.delete();
    push(40);
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (fifo_rd_en) begin
        found = 1;
        break;
      end
      adv();
    end
    if (!found) begin
      fail_now("rst_rd_timeout");
    end else begin
      rst = 1'b1;
      adv();
      rst = 1'b0;
      look();
      check("mrst_state", int'(state), 0);
      check("mrst_rd_en", int'(fifo_rd_en), 0);
      check("mrst_valid", int'(dac_valid), 0);
      check("mrst_underrun", int'(underrun), 0);
      check("mrst_dac_data", int'(dac_data), 'h2000);
      adv();
      look();
      check("mrst_no_valid", int'(dac_valid), 0);
      adv();
    end
    enable = 1'b0;
    look();
    adv();

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    q.delete();
    upd_fifo();
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(32);
      found = 0;
      for (int i = 0; i < 300; i++) begin
        look();
        if (underrun) begin
          found = 1;
          adv();
          break;
        end
        adv();
      end
      if (!found) fail_now("cnt_underrun_timeout");
    end
    look();
    check("underrun_cnt_3", int'(underrun_cnt), 3);
    enable = 1'b0;
    rst = 1'b1;
    adv();
    rst = 1'b0;
    look();
    check("underrun_cnt_clr", int'(underrun_cnt), 0);
    adv();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
